// File: rtl/banked_ram_ctrl.sv
// NBANKS x DEPTH x WIDTH single-port RAM behind one valid/ready command port.
// Supports read (1-cycle latency), write, and a whole-bank clear sweep.
module banked_ram_ctrl #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 100,
  parameter int NBANKS = 4,
  parameter int BANK_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [BANK_W-1:0] cmd_bank,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [WIDTH-1:0]  cmd_wdata,
  output logic              rd_valid,
  output logic [WIDTH-1:0]  rd_data,
  output logic [BANK_W-1:0] rd_bank,
  output logic              err,
  output logic              busy
);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [BANK_W:0] NB_L   = NBANKS[BANK_W:0];
  localparam logic [ADDR_W:0] DP_L   = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [BANK_W-1:0]   clr_bank_q;
  logic                rd_valid_q, err_q;
  logic [WIDTH-1:0]    rd_data_q;
  logic [BANK_W-1:0]   rd_bank_q;
  logic [WIDTH-1:0]    mem_q [NBANKS][DEPTH];

  logic cmd_fire, cmd_legal, bank_ok, addr_ok;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == CLEAR);
  assign cmd_fire  = cmd_valid & cmd_ready;

  assign bank_ok   = ({1'b0, cmd_bank} < NB_L);
  assign addr_ok   = ({1'b0, cmd_addr} < DP_L);
  assign cmd_legal = (cmd_op != OP_RSV) && bank_ok && (cmd_op == OP_CLR || addr_ok);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire && cmd_legal && cmd_op == OP_CLR) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // Terminal compare on DEPTH-1 so non-power-of-two depths stop exactly.
        if (cnt_q == LAST) state_d = IDLE;
        else               cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_bank_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_bank_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= cmd_fire && cmd_legal && cmd_op == OP_RD;
      err_q      <= cmd_fire && !cmd_legal;
      if (cmd_fire && cmd_legal && cmd_op == OP_CLR) clr_bank_q <= cmd_bank;
      if (cmd_fire && cmd_legal && cmd_op == OP_RD) begin
        rd_data_q <= mem_q[cmd_bank][cmd_addr];
        rd_bank_q <= cmd_bank;
      end
    end
  end

  // Storage is not reset; reset only suppresses the write on its edge so an
  // aborted sweep leaves the bank partially cleared.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR)
        mem_q[clr_bank_q][cnt_q] <= '0;
      else if (cmd_fire && cmd_legal && cmd_op == OP_WR)
        mem_q[cmd_bank][cmd_addr] <= cmd_wdata;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_bank  = rd_bank_q;
  assign err      = err_q;

endmodule

// File: tb/tb_banked_ram_ctrl.sv
// Scoreboard bench for banked_ram_ctrl: driver pushes expected responses from
// an array reference model, a negedge monitor pops and compares.
module tb_banked_ram_ctrl;
  localparam int DEPTH = 100;
  localparam int NB    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [1:0] cmd_bank = '0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [1:0] rd_bank;
  logic       err;
  logic       busy;

  banked_ram_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_bank(cmd_bank), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_bank(rd_bank), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {bit is_err; logic [7:0] data; logic [1:0] bank;} exp_t;
  exp_t       exq[$];
  logic [7:0] ref_mem [NB][DEPTH];
  logic [7:0] last_d = '0;
  logic [1:0] last_b = '0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input bit ok, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model applied at the accepting edge.
  task automatic model_accept(input logic [1:0] op, input int bank, input int addr, input logic [7:0] wd);
    exp_t e;
    bit legal;
    legal = (op != 2'b11) && (bank < NB) && (op == 2'b10 || addr < DEPTH);
    if (!legal) begin
      e.is_err = 1; e.data = '0; e.bank = '0;
      exq.push_back(e);
    end else if (op == 2'b00) begin
      e.is_err = 0; e.data = ref_mem[bank][addr]; e.bank = bank[1:0];
      exq.push_back(e);
    end else if (op == 2'b01) begin
      ref_mem[bank][addr] = wd;
    end else begin
      for (int a = 0; a < DEPTH; a++) ref_mem[bank][a] = 8'h00;
    end
  endtask

  // Drive at negedge; accepted on the first posedge seen with cmd_ready=1.
  task automatic issue(input logic [1:0] op, input int bank, input int addr,
                       input logic [7:0] wd, output int waits);
    cmd_op = op; cmd_bank = bank[1:0]; cmd_addr = addr[6:0]; cmd_wdata = wd;
    cmd_valid = 1'b1;
    waits = 0;
    while (!cmd_ready && waits < 2000) begin
      @(negedge clk);
      waits++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, waits, 0);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(op, bank, addr, wd);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        last_d = '0; last_b = '0;
      end else begin
        if (rd_valid && err) chk("rdv_and_err", 0, 1, 0);
        if (rd_valid || err) begin
          if (exq.size() == 0) chk("unexpected_output", 0, {rd_valid, err}, 0);
          else begin
            e = exq.pop_front();
            chk("resp_kind_err", err == e.is_err, err, e.is_err);
            if (!e.is_err) begin
              chk("rd_data", rd_data == e.data, rd_data, e.data);
              chk("rd_bank", rd_bank == e.bank, rd_bank, e.bank);
              last_d = e.data; last_b = e.bank;
            end
          end
        end else begin
          chk("rd_hold", rd_data == last_d && rd_bank == last_b, {rd_bank, rd_data}, {last_b, last_d});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w, n;
    bit ok;
    logic [7:0] saved [DEPTH];
    logic [1:0] op;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready == 1'b1, cmd_ready, 1);
    chk("rst_outs", {rd_valid, err, busy} == 3'b000, {rd_valid, err, busy}, 0);
    chk("rst_data", {rd_bank, rd_data} == '0, {rd_bank, rd_data}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Fill memory so the model is fully defined
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++)
        issue(2'b01, b, a, 8'($urandom), w);

    // 1: write then read next cycle
    issue(2'b01, 2, 5, 8'hA5, w);
    issue(2'b00, 2, 5, 8'h00, w);
    chk("t1_model", ref_mem[2][5] == 8'hA5, ref_mem[2][5], 8'hA5);
    idle(2);

    // 2: distinct writes to addr7, back-to-back reads
    for (int b = 0; b < NB; b++) issue(2'b01, b, 7, 8'(8'h30 + b), w);
    for (int b = 0; b < NB; b++) issue(2'b00, b, 7, 8'h00, w);
    idle(2);

    // 3: illegal address and reserved op
    issue(2'b00, 0, 100, 8'h00, w);
    issue(2'b11, 1, 3, 8'h00, w);
    issue(2'b01, 0, 127, 8'hEE, w);
    issue(2'b00, 0, 99, 8'h00, w);
    idle(2);

    // 4: fill bank1 with FF, clear, count busy cycles
    for (int a = 0; a < DEPTH; a++) issue(2'b01, 1, a, 8'hFF, w);
    issue(2'b10, 1, 0, 8'h00, w);
    n = 0; ok = 1;
    while (busy && n < 1000) begin
      if (cmd_ready) ok = 0;
      @(negedge clk);
      n++;
    end
    chk("t4_busy_cycles", n == DEPTH, n, DEPTH);
    chk("t4_ready_low", ok, ok, 1);
    issue(2'b00, 1, 0, 8'h00, w);
    issue(2'b00, 1, 50, 8'h00, w);
    issue(2'b00, 1, 99, 8'h00, w);
    issue(2'b00, 0, 50, 8'h00, w);
    issue(2'b00, 0, 99, 8'h00, w);
    idle(2);

    // 5: reset in sweep cycle 40 of a bank3 clear
    for (int a = 0; a < DEPTH; a++) saved[a] = ref_mem[3][a];
    issue(2'b10, 3, 0, 8'h00, w);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_ready", cmd_ready == 1'b1, cmd_ready, 1);
    chk("t5_rst_outs", {rd_valid, err, busy} == 3'b000, {rd_valid, err, busy}, 0);
    chk("t5_rst_data", {rd_bank, rd_data} == '0, {rd_bank, rd_data}, 0);
    for (int a = 40; a < DEPTH; a++) ref_mem[3][a] = saved[a];
    for (int a = 0; a < DEPTH; a++) issue(2'b00, 3, a, 8'h00, w);
    idle(2);

    // 6: read held during a clear is accepted on the first ready edge
    issue(2'b01, 2, 10, 8'h77, w);
    issue(2'b10, 2, 0, 8'h00, w);
    issue(2'b00, 2, 10, 8'h00, w);
    chk("t6_wait_cycles", w == DEPTH, w, DEPTH);
    idle(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      n = $urandom_range(0, 99);
      op = (n < 3) ? 2'b11 : (n < 6) ? 2'b10 : (n < 50) ? 2'b00 : 2'b01;
      issue(op, $urandom_range(0, NB - 1),
            ($urandom_range(0, 9) == 0) ? $urandom_range(100, 127) : $urandom_range(0, DEPTH - 1),
            8'($urandom), w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(4);
    chk("scoreboard_drained", exq.size() == 0, exq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
